// File: rtl/vend_pkg.sv
// -----------------------------------------------------------------------------
// vend_pkg
// Shared definitions for the cola dispense arbiter:
//   - FSM state encoding (S_IDLE / S_DISPENSE / S_CHANGE) and the enum built on it
//   - coin value constants in 0.5-yuan units
//   - default price / dispenser time / change gap
//   - small constant helper used for counter sizing
// -----------------------------------------------------------------------------
package vend_pkg;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DISPENSE = 2'd1;
  localparam logic [1:0] S_CHANGE   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE     = S_IDLE,
    ST_DISPENSE = S_DISPENSE,
    ST_CHANGE   = S_CHANGE
  } state_e;

  // Coin values in 0.5-yuan credit units.
  localparam int unsigned COIN_HALF = 1;
  localparam int unsigned COIN_ONE  = 2;

  localparam int unsigned DEF_PRICE    = 5;
  localparam int unsigned DEF_DISP_CYC = 8;
  localparam int unsigned DEF_CHG_GAP  = 2;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vend_rr_arb.sv
// -----------------------------------------------------------------------------
// vend_rr_arb
// Purely combinational round-robin picker. Returns the first requesting
// station at or after the pointer, wrapping around. The pointer register lives
// in the parent so it only advances when a service actually completes.
// Ports:
//   req_i      in   N   request vector (one bit per station)
//   ptr_i      in   IW  index of the highest-priority station this cycle
//   gnt_o      out  N   one-hot grant (all zero when no request)
//   gnt_idx_o  out  IW  binary index of the granted station
//   gnt_vld_o  out  1   some station was granted
// -----------------------------------------------------------------------------
module vend_rr_arb
  import vend_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          gnt_vld_o
);

  // NOTE: every output gets a default at the top of the block so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    int unsigned j;
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    j         = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!gnt_vld_o && req_i[j]) begin
        gnt_vld_o = 1'b1;
        gnt_o[j]  = 1'b1;
        gnt_idx_o = IW'(j);
      end
    end
  end

endmodule

// File: rtl/vend_dispense_arb.sv
// -----------------------------------------------------------------------------
// vend_dispense_arb
// Shares one cola dispenser and one change hopper between N_STATION coin
// stations. Each station accumulates credit in 0.5-yuan units; once credit
// reaches PRICE the station locks and waits for a round-robin grant. The
// served station gets DISP_CYC cycles of dispenser time, a 1-cycle cola
// pulse, then its surplus back as 0.5-yuan pulses spaced CHG_GAP idle cycles.
//
// Build option: define VEND_CANCEL_EN to add pi_cancel, which lets an unlocked
// station with credit ask for a full refund through the same arbitration
// (served straight from IDLE into CHANGE, no dispense).
//
// Ports:
//   clk            in   1  system clock
//   rst_n          in   1  synchronous reset, active-low
//   pi_coin_vld    in   N  1-cycle coin strobe per station
//   pi_coin_one    in   N  coin value when vld: 1 = 1.0 yuan, 0 = 0.5 yuan
//   pi_cancel      in   N  refund request (VEND_CANCEL_EN builds only)
//   po_coin_rej    out  N  1-cycle pulse: coin rejected (station locked)
//   po_disp_busy   out  1  dispenser running
//   po_cola        out  N  1-cycle dispense-complete pulse
//   po_back_money  out  N  1-cycle pulse per 0.5-yuan change unit
//   po_locked      out  N  station pending or being served
// -----------------------------------------------------------------------------
module vend_dispense_arb
  import vend_pkg::*;
#(
  parameter int unsigned N_STATION = 2,
  parameter int unsigned PRICE     = DEF_PRICE,
  parameter int unsigned DISP_CYC  = DEF_DISP_CYC,
  parameter int unsigned CHG_GAP   = DEF_CHG_GAP
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_STATION-1:0] pi_coin_vld,
  input  logic [N_STATION-1:0] pi_coin_one,
`ifdef VEND_CANCEL_EN
  input  logic [N_STATION-1:0] pi_cancel,
`endif
  output logic [N_STATION-1:0] po_coin_rej,
  output logic                 po_disp_busy,
  output logic [N_STATION-1:0] po_cola,
  output logic [N_STATION-1:0] po_back_money,
  output logic [N_STATION-1:0] po_locked
);

  localparam int unsigned CW      = $clog2(PRICE + 2);
  localparam int unsigned IW      = (N_STATION > 1) ? $clog2(N_STATION) : 1;
  localparam int unsigned CNT_MAX = max2(DISP_CYC, CHG_GAP);
  localparam int unsigned CNTW    = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0]   PRICE_C    = CW'(PRICE);
  localparam logic [CNTW-1:0] DISP_END   = CNTW'(DISP_CYC);
  localparam logic [CNTW-1:0] DISP_LAST  = CNTW'(DISP_CYC - 1);
  localparam logic [CNTW-1:0] GAP_LOAD   = CNTW'(CHG_GAP);
  localparam logic [IW-1:0]   LAST_STN   = IW'(N_STATION - 1);

  // Per-station credit and lock state.
  logic [CW-1:0]        credit_q [N_STATION];
  logic [CW-1:0]        credit_d [N_STATION];
  logic [N_STATION-1:0] locked_q, locked_d;
  logic [N_STATION-1:0] refund_q, refund_d;
  logic [N_STATION-1:0] rej_q, rej_d;

  // Service FSM.
  state_e               state_q;
  logic [CNTW-1:0]      cnt_q;       // dispense length, then change gap
  logic [IW-1:0]        g_q;         // station being served
  logic [N_STATION-1:0] g_oh_q;
  logic [IW-1:0]        rr_q;
  logic                 busy_q;
  logic [N_STATION-1:0] cola_q;
  logic [N_STATION-1:0] back_q;

  logic [N_STATION-1:0] arb_gnt;
  logic [IW-1:0]        arb_idx;
  logic                 arb_vld;

  logic [CW-1:0]        g_credit;
  logic                 disp_exit;
  logic                 chg_pulse;
  logic                 svc_done;
  logic [IW-1:0]        rr_next;

  // A locked station is exactly a station waiting for (or in) service; only
  // IDLE acts on the grant, so no masking of the served station is needed.
  vend_rr_arb #(
    .N  (N_STATION),
    .IW (IW)
  ) u_arb (
    .req_i     (locked_q),
    .ptr_i     (rr_q),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx),
    .gnt_vld_o (arb_vld)
  );

  assign g_credit  = credit_q[g_q];
  assign disp_exit = (state_q == ST_DISPENSE) && (cnt_q == DISP_END);
  assign chg_pulse = (state_q == ST_CHANGE) && (cnt_q == '0) && (g_credit != '0);
  // Service ends when dispense leaves nothing to return, or on the cycle after
  // the change pulse that emptied the credit.
  assign svc_done  = (disp_exit && (g_credit == PRICE_C)) ||
                     ((state_q == ST_CHANGE) && (g_credit == '0));
  assign rr_next   = (g_q == LAST_STN) ? '0 : g_q + IW'(1);

  // ---------------------------------------------------------------------------
  // Credit / lock next-state. Coin handling uses the lock value of the strobe
  // cycle; the served station is always locked, so its coins are rejected and
  // the FSM-driven decrements never collide with a coin add.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < N_STATION; i++) begin
      credit_d[i] = credit_q[i];
      locked_d[i] = locked_q[i];
      refund_d[i] = refund_q[i];
      rej_d[i]    = 1'b0;

      if (pi_coin_vld[i]) begin
        if (locked_q[i]) begin
          rej_d[i] = 1'b1;
        end else begin
          credit_d[i] = credit_q[i] + (pi_coin_one[i] ? CW'(COIN_ONE) : CW'(COIN_HALF));
        end
      end

`ifdef VEND_CANCEL_EN
      // Refund eligibility looks at the credit held before any same-cycle coin;
      // the coin itself is still accepted and becomes part of the refund.
      if (pi_cancel[i] && !locked_q[i] && (credit_q[i] != '0)) begin
        refund_d[i] = 1'b1;
        locked_d[i] = 1'b1;
      end
`endif

      if (!locked_q[i] && (credit_d[i] >= PRICE_C)) begin
        locked_d[i] = 1'b1;
      end

      if (IW'(i) == g_q) begin
        if (disp_exit) credit_d[i] = credit_q[i] - PRICE_C;
        if (chg_pulse) credit_d[i] = credit_q[i] - CW'(1);
        if (svc_done) begin
          locked_d[i] = 1'b0;
          refund_d[i] = 1'b0;
        end
      end
    end
  end

  // NOTE: the credit array is real architectural state (not a RAM), so every
  // entry is cleared on reset; leaving it unreset would let stale credit
  // survive a reset and trigger a free cola.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_STATION; i++) credit_q[i] <= '0;
      locked_q <= '0;
      refund_q <= '0;
      rej_q    <= '0;
    end else begin
      for (int i = 0; i < N_STATION; i++) credit_q[i] <= credit_d[i];
      locked_q <= locked_d;
      refund_q <= refund_d;
      rej_q    <= rej_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Service FSM with registered outputs. The grant cycle moves to DISPENSE and
  // the busy output follows one edge later, so busy runs DISP_CYC cycles while
  // the state spends one extra cycle deciding where to exit.
  // ---------------------------------------------------------------------------
  // NOTE: all state and output registers use non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      g_q     <= '0;
      g_oh_q  <= '0;
      rr_q    <= '0;
      busy_q  <= 1'b0;
      cola_q  <= '0;
      back_q  <= '0;
    end else begin
      cola_q <= '0;
      back_q <= '0;
      unique case (state_q)
        ST_IDLE: begin
          busy_q <= 1'b0;
          cnt_q  <= '0;
          if (arb_vld) begin
            g_q     <= arb_idx;
            g_oh_q  <= arb_gnt;
            state_q <= ((refund_q & arb_gnt) != '0) ? ST_CHANGE : ST_DISPENSE;
          end
        end

        ST_DISPENSE: begin
          if (disp_exit) begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= svc_done ? ST_IDLE : ST_CHANGE;
            if (svc_done) rr_q <= rr_next;
          end else begin
            busy_q <= 1'b1;
            cola_q <= (cnt_q == DISP_LAST) ? g_oh_q : '0;
            cnt_q  <= cnt_q + CNTW'(1);
          end
        end

        ST_CHANGE: begin
          if (svc_done) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rr_q    <= rr_next;
          end else if (chg_pulse) begin
            back_q <= g_oh_q;
            cnt_q  <= GAP_LOAD;
          end else begin
            cnt_q <= cnt_q - CNTW'(1);
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign po_coin_rej   = rej_q;
  assign po_disp_busy  = busy_q;
  assign po_cola       = cola_q;
  assign po_back_money = back_q;
  assign po_locked     = locked_q;

endmodule

// File: tb/tb_vend_dispense_arb.sv
// -----------------------------------------------------------------------------
// tb_vend_dispense_arb
// Scoreboard bench for vend_dispense_arb (defaults: 2 stations, price 5,
// dispense 8 cycles, change gap 2). A reference model computes, at grant time,
// the whole service timeline (busy window, cola edge, change pulse times,
// release edge) and pushes each expected output pulse as it falls due; a
// separate negedge monitor pops and compares every pulse the DUT shows.
// -----------------------------------------------------------------------------
module tb_vend_dispense_arb;

  localparam int N     = 2;
  localparam int PRICE = 5;
  localparam int D     = 8;
  localparam int GAP   = 2;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] vld   = '0;
  logic [N-1:0] one   = '0;
`ifdef VEND_CANCEL_EN
  logic [N-1:0] cancel = '0;
`endif
  logic [N-1:0] po_coin_rej;
  logic         po_disp_busy;
  logic [N-1:0] po_cola;
  logic [N-1:0] po_back_money;
  logic [N-1:0] po_locked;

  always #5 clk = ~clk;

  vend_dispense_arb #(
    .N_STATION (N),
    .PRICE     (PRICE),
    .DISP_CYC  (D),
    .CHG_GAP   (GAP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pi_coin_vld   (vld),
    .pi_coin_one   (one),
`ifdef VEND_CANCEL_EN
    .pi_cancel     (cancel),
`endif
    .po_coin_rej   (po_coin_rej),
    .po_disp_busy  (po_disp_busy),
    .po_cola       (po_cola),
    .po_back_money (po_back_money),
    .po_locked     (po_locked)
  );

  typedef enum int {EV_BUSY = 1, EV_COLA = 2, EV_BACK = 3, EV_REJ = 4} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       st;
    int       cyc;
  } ev_t;

  ev_t exp_q[$];
  int  cyc      = 0;
  int  n_checks = 0;
  int  n_pass   = 0;

  // Observed-pulse statistics for the directed scenarios.
  int busy_cnt = 0;
  int cola_cnt[N];
  int back_cnt[N];
  int rej_cnt[N];
  int cola_order[$];

  // Reference model state.
  int           m_credit[N];
  logic [N-1:0] m_locked;
  logic [N-1:0] m_refund;
  int           m_srv;
  int           m_rr;
  int           t_busy0, t_busy1, t_cola, t_sub, t_p0, t_rel, n_pulse;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int ev_code(input ev_kind_e k, input int st, input int c);
    return int'(k) * 1000000 + st * 100000 + c;
  endfunction

  // ---------------- reference model ----------------
  task automatic push(input ev_kind_e k, input int st);
    ev_t e;
    e.kind = k;
    e.st   = st;
    e.cyc  = cyc;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_credit[i] = 0;
    m_locked = '0;
    m_refund = '0;
    m_srv    = -1;
    m_rr     = 0;
    exp_q.delete();
  endtask

  // Plan a whole service from the grant edge cyc.
  task automatic start_service(input int g, input int credit);
    m_srv = g;
    if (m_refund[g]) begin
      t_busy0 = -1; t_busy1 = -2; t_cola = -1; t_sub = -1;
      n_pulse = credit;
      t_p0    = cyc + 1;
      t_rel   = t_p0 + (n_pulse - 1) * (GAP + 1) + 1;
    end else begin
      t_busy0 = cyc + 1;
      t_busy1 = cyc + D;
      t_cola  = cyc + D;
      t_sub   = cyc + D + 1;
      n_pulse = credit - PRICE;
      t_p0    = t_sub + 1;
      t_rel   = (n_pulse > 0) ? t_p0 + (n_pulse - 1) * (GAP + 1) + 1 : t_sub;
    end
  endtask

  task automatic model_step();
    logic [N-1:0] lk;
    int           cr[N];
    int           g;
    lk = m_locked;
    for (int i = 0; i < N; i++) cr[i] = m_credit[i];

    if (m_srv < 0) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_rr + k) % N;
        if (m_srv < 0 && lk[j]) start_service(j, cr[j]);
      end
    end else begin
      g = m_srv;
      if (cyc >= t_busy0 && cyc <= t_busy1) push(EV_BUSY, 0);
      if (cyc == t_cola) push(EV_COLA, g);
      if (cyc == t_sub) m_credit[g] -= PRICE;
      if (n_pulse > 0 && cyc >= t_p0 && (cyc - t_p0) % (GAP + 1) == 0 &&
          (cyc - t_p0) / (GAP + 1) < n_pulse) begin
        push(EV_BACK, g);
        m_credit[g] -= 1;
      end
      if (cyc == t_rel) begin
        m_locked[g] = 1'b0;
        m_refund[g] = 1'b0;
        m_srv       = -1;
        m_rr        = (g + 1) % N;
      end
    end

    for (int i = 0; i < N; i++) begin
      if (vld[i]) begin
        if (lk[i]) push(EV_REJ, i);
        else m_credit[i] += one[i] ? 2 : 1;
      end
`ifdef VEND_CANCEL_EN
      if (cancel[i] && !lk[i] && cr[i] > 0) begin
        m_refund[i] = 1'b1;
        m_locked[i] = 1'b1;
      end
`endif
      if (!lk[i] && m_credit[i] >= PRICE) m_locked[i] = 1'b1;
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) model_reset();
    else model_step();
  end

  // ---------------- monitor ----------------
  task automatic match(input ev_kind_e k, input int st);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL unexpected_pulse: got %0d, expected no pulse (cycle %0d)", ev_code(k, st, cyc), cyc);
    end else begin
      e = exp_q.pop_front();
      check("pulse", ev_code(k, st, cyc), ev_code(e.kind, e.st, e.cyc));
    end
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      ev_t e;
      e = exp_q.pop_front();
      n_checks++;
      $display("FAIL missing_pulse: got none, expected %0d (cycle %0d)", ev_code(e.kind, e.st, e.cyc), cyc);
    end
    if (po_disp_busy === 1'b1) begin busy_cnt++; match(EV_BUSY, 0); end
    for (int i = 0; i < N; i++)
      if (po_cola[i] === 1'b1) begin cola_cnt[i]++; cola_order.push_back(i); match(EV_COLA, i); end
    for (int i = 0; i < N; i++)
      if (po_back_money[i] === 1'b1) begin back_cnt[i]++; match(EV_BACK, i); end
    for (int i = 0; i < N; i++)
      if (po_coin_rej[i] === 1'b1) begin rej_cnt[i]++; match(EV_REJ, i); end
    check("locked", 64'(po_locked), 64'(m_locked));
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] o);
    vld = v;
    one = o;
    @(negedge clk);
    vld = '0;
    one = '0;
  endtask

  task automatic wait_quiet(input string name, input int budget);
    int n;
    n = 0;
    while (!(m_srv < 0 && m_locked == '0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      n_checks++;
      $display("FAIL %s: service still running after %0d cycles, expected idle", name, budget);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_out(input string name, input bit want_cola, input int budget);
    int n;
    n = 0;
    while (!((want_cola ? po_cola[0] : po_disp_busy) === 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      n_checks++;
      $display("FAIL %s: output never rose within %0d cycles, expected 1", name, budget);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic int order2();
    return (cola_order.size() >= 2) ? cola_order[0] * 10 + cola_order[1] : -1;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int c0, c1, b0, b1, r0, r1, bz;
    for (int i = 0; i < N; i++) begin cola_cnt[i] = 0; back_cnt[i] = 0; rej_cnt[i] = 0; end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_locked", 64'(po_locked), 0);
    check("rst_busy",   64'(po_disp_busy), 0);
    check("rst_cola",   64'(po_cola), 0);
    check("rst_back",   64'(po_back_money), 0);
    check("rst_rej",    64'(po_coin_rej), 0);

    // 1: exact price, no change.
    c0 = cola_cnt[0]; b0 = back_cnt[0]; bz = busy_cnt;
    drive(2'b01, 2'b01); drive(2'b01, 2'b01); drive(2'b01, 2'b00);
    wait_quiet("t1_done", 100);
    check("t1_cola0", cola_cnt[0] - c0, 1);
    check("t1_back0", back_cnt[0] - b0, 0);
    check("t1_busy_len", busy_cnt - bz, D);
    check("t1_unlocked", 64'(po_locked), 0);

    // 2: one unit of change.
    c0 = cola_cnt[0]; b0 = back_cnt[0];
    drive(2'b01, 2'b01); drive(2'b01, 2'b01); drive(2'b01, 2'b01);
    wait_quiet("t2_done", 100);
    check("t2_cola0", cola_cnt[0] - c0, 1);
    check("t2_back0", back_cnt[0] - b0, 1);

    // 3: both pending together after reset, twice: station 0 first each time.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      cola_order.delete();
      drive(2'b11, 2'b11); drive(2'b11, 2'b11); drive(2'b11, 2'b00);
      wait_quiet("t3_done", 150);
      check("t3_order", order2(), 1);
    end

    // 4: coin on the dispensing station is rejected, coin on the other accepted.
    drive(2'b01, 2'b01); drive(2'b01, 2'b01); drive(2'b01, 2'b00);
    wait_out("t4_busy", 1'b0, 20);
    r0 = rej_cnt[0]; r1 = rej_cnt[1]; c1 = cola_cnt[1];
    drive(2'b11, 2'b00);
    @(negedge clk);
    check("t4_rej0", rej_cnt[0] - r0, 1);
    check("t4_rej1", rej_cnt[1] - r1, 0);
    wait_quiet("t4_st0_done", 100);
    drive(2'b10, 2'b10); drive(2'b10, 2'b10);
    wait_quiet("t4_st1_done", 100);
    check("t4_cola1", cola_cnt[1] - c1, 1);

    // 5: reset while in CHANGE aborts the pulse and resets the pointer.
    b0 = back_cnt[0];
    drive(2'b01, 2'b01); drive(2'b01, 2'b01); drive(2'b01, 2'b01);
    wait_out("t5_cola", 1'b1, 30);
    @(negedge clk);
    do_reset();
    check("t5_locked", 64'(po_locked), 0);
    check("t5_busy",   64'(po_disp_busy), 0);
    check("t5_cola",   64'(po_cola), 0);
    check("t5_back",   64'(po_back_money), 0);
    check("t5_rej",    64'(po_coin_rej), 0);
    repeat (5) @(negedge clk);
    check("t5_no_change", back_cnt[0] - b0, 0);
    cola_order.delete();
    drive(2'b11, 2'b11); drive(2'b11, 2'b11); drive(2'b11, 2'b00);
    wait_quiet("t5_done", 150);
    check("t5_order", order2(), 1);

`ifdef VEND_CANCEL_EN
    // 6: refund of 3 units on station 1.
    c1 = cola_cnt[1]; b1 = back_cnt[1];
    drive(2'b10, 2'b10); drive(2'b10, 2'b00);
    cancel = 2'b10;
    @(negedge clk);
    cancel = '0;
    wait_quiet("t6_done", 100);
    check("t6_cola1", cola_cnt[1] - c1, 0);
    check("t6_back1", back_cnt[1] - b1, 3);
`endif

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < N; i++) begin
        vld[i] = ($urandom_range(0, 3) == 0);
        one[i] = $urandom_range(0, 1) == 1;
`ifdef VEND_CANCEL_EN
        cancel[i] = ($urandom_range(0, 15) == 0);
`endif
      end
      @(negedge clk);
    end
    vld = '0;
    one = '0;
`ifdef VEND_CANCEL_EN
    cancel = '0;
`endif
    wait_quiet("rand_done", 300);
    check("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
